// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with registered active-low seven-segment outputs.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown). count, wrap and ovf are the same in both builds.
module bcd_counter_display #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   disp,
  output logic                  wrap,
  output logic                  ovf
);

  localparam int unsigned CountW = 4 * DIGITS;
  localparam int unsigned DispW  = 7 * DIGITS;

  logic [CountW-1:0] count_q, count_d;
  logic [DispW-1:0]  disp_q, disp_d;
  logic              wrap_q, wrap_d;
  logic              ovf_q, ovf_d;
  logic              ripple;
  logic [3:0]        ld_digit;
  logic [3:0]        dsp_digit;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic              lead_zero;
`endif

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Next count: load > (inc & dec) > inc > dec, per-digit ripple carry/borrow.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    ovf_d    = ovf_q;
    ripple   = 1'b0;
    ld_digit = 4'd0;
    if (load) begin
      ovf_d = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        ld_digit = load_val[4*k +: 4];
        count_d[4*k +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
      end
    end else if (inc && dec) begin
      // Conflicting requests cancel; hold.
      count_d = count_q;
    end else if (inc) begin
      ripple = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (ripple) begin
          if (count_q[4*k +: 4] == 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end
      end
      // Carry out of the top digit means all-9s rolled to zero.
      if (ripple) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end
    end else if (dec) begin
      ripple = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (ripple) begin
          if (count_q[4*k +: 4] == 4'd0) begin
            count_d[4*k +: 4] = 4'd9;
          end else begin
            count_d[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
      if (ripple) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end
    end
  end

  // Decode the registered count; walks from the top digit to track leading zeros.
  always_comb begin
    disp_d    = '0;
    dsp_digit = 4'd0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    lead_zero = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dsp_digit = count_q[4*k +: 4];
      disp_d[7*k +: 7] = seg7(dsp_digit);
`ifdef BCD_LEADING_ZERO_BLANK_EN
      if ((k != 0) && lead_zero && (dsp_digit == 4'd0)) begin
        disp_d[7*k +: 7] = 7'b1111111;
      end
      lead_zero = lead_zero & (dsp_digit == 4'd0);
`endif
    end
  end

  // Counter, wrap pulse and sticky overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display register; lags count by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DIGITS; k++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        disp_q[7*k +: 7] <= (k == 0) ? 7'b1000000 : 7'b1111111;
`else
        disp_q[7*k +: 7] <= 7'b1000000;
`endif
      end
    end else begin
      disp_q <= disp_d;
    end
  end

  assign count = count_q;
  assign disp  = disp_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parametrised N-digit BCD up/down counter that drives one active-low seven-segment display per digit.
- Replaces fixed two-digit static displays with a stateful multi-digit readout.
- Supports load, increment, decrement, wrap-around and a sticky overflow flag.
- Sits between board push-button/pulse logic and the HEX display pins.

Parameters:
- DIGITS, 2, number of BCD digits and seven-segment displays (1..8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- inc  input  1  single-cycle increment request (sampled each rising edge).
- dec  input  1  single-cycle decrement request.
- load  input  1  load load_val into the counter.
- load_val  input  4*DIGITS  BCD value to load; digit k at bits [4k+3:4k], digit 0 least significant.
- count  output  4*DIGITS  current BCD count (registered).
- disp  output  7*DIGITS  segment outputs; display k at bits [7k+6:7k]; within each display bit order {g,f,e,d,c,b,a}, active-low.
- wrap  output  1  one-cycle pulse when a count wraps.
- ovf  output  1  sticky flag, set on any wrap.

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, including mid-operation:
  - count = 0
  - every display = 7'b1000000 ("0")
  - wrap = 0
  - ovf = 0
- Command priority, evaluated each rising edge: load > (inc & dec) > inc > dec.
- Load:
  - count <= load_val.
  - Any digit > 9 is clamped to 9.
  - ovf cleared; wrap = 0.
- inc and dec in the same cycle (without load): no change; wrap = 0.
- inc:
  - Ripple BCD add of 1: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
  - At all-9s, count becomes 0, wrap = 1 for exactly one cycle, ovf set.
- dec:
  - Ripple BCD subtract of 1: a digit at 0 becomes 9 and borrows from the next digit.
  - At 0, count becomes all-9s, wrap = 1 for one cycle, ovf set.
- Idle (no command): count held; wrap = 0; ovf held.
- Latency:
  - count and wrap change on the same edge that samples the command.
  - disp is registered from count and updates one cycle later. After a command at edge N, count is new at N and disp is new at N+1.
- Segment encoding, active-low, {g..a}:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Non-BCD codes (unreachable) display 1111111 (blank).
- ovf remains set across further inc/dec until load or reset.
- No internal counters beyond the digit registers; all arithmetic is per-digit 4-bit with explicit carry/borrow chain, and no binary-to-BCD conversion.

Optional Feature:
- Macro BCD_LEADING_ZERO_BLANK_EN.
- When defined:
  - Any digit that is 0 and has all more-significant digits also 0 is blanked (display = 1111111).
  - Digit 0 is never blanked, so a count of 0 shows a single "0".
  - Reset value for display 0 is 1000000; all other displays reset to 1111111.
  - Blanking is applied in the same registered stage as decoding, so disp latency is unchanged.
- When undefined: every digit is always decoded; leading zeros are shown.
- count, wrap and ovf are identical in both builds.

Test Plan:
- DIGITS=2: reset asserted mid-count, e.g. count=47 →
  - count=00, disp=1000000_1000000, wrap=0, ovf=0 immediately, without waiting for a clock edge.
- Load 8'h38 then 3 inc pulses →
  - count 38→39→40→41, showing digit carry at 39→40.
  - disp lags count by one cycle.
  - disp for 41 = 0011001_1111001.
- Load 8'h99, one inc →
  - count=00, wrap=1 for one cycle only, ovf=1.
  - Further inc gives 01 with ovf still 1.
  - Load 8'h05 clears ovf.
- Load 8'h00, one dec →
  - count=99, wrap pulse, ovf=1.
  - Then load 8'hA7 → count=97 (tens digit clamped).
- inc and dec asserted together at count=50 → count stays 50, wrap=0. Then load and inc together with load_val=8'h12 → count=12.
- With BCD_LEADING_ZERO_BLANK_EN defined and DIGITS=4, load 16'h0070 →
  - disp = 1111111_1111111_1111000_1000000.
  - Load 0 → only display 0 shows 1000000.
